instr_dispatch: RTL
===================

# instr_dispatch

Read-side consumer for the instruction FIFO. It pops 85-bit FIFO words (children + flit) and drops any word whose valid bit is clear. Each remaining word is expanded into a 91-bit reduction-table entry that carries LeafBit, ExtraWaitBit and waitcount. Entries go to the reduction table over a valid/ready handshake, and the block keeps saturating dispatch and drop counters for debug.

## Interface
- FlitWidth, 82, flit width: valid bit at [81], payload at [31:0]
- ChildWidth, 3, children field width: FIFO word bits [84:82]
- WaitWidth, 4, waitcount width: entry bits [88:85]
- WaitLatency, 4'd9, waitcount loaded for non-leaf entries; must be nonzero
- CntWidth, 16, width of the debug counters
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- enable  in  1  permits starting a new FIFO read
- fifo_empty  in  1  FIFO buf_empty
- fifo_data  in  85  FIFO buf_out; updated the edge after a qualified rd_en
- fifo_rd_en  out  1  FIFO rd_en; combinational from state and inputs
- out_valid  out  1  entry valid
- out_ready  in  1  reduction table accepts the entry
- out_entry  out  91  {LeafBit, ExtraWaitBit, waitcount, fifo word}
- dispatch_count  out  CntWidth  entries accepted downstream; saturating
- drop_count  out  CntWidth  words discarded for valid=0; saturating
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, WAIT, OUT. Reset state is IDLE.
- fifo_rd_en = (IDLE & enable & !fifo_empty) | (OUT & out_ready & !fifo_empty & enable).
- Transitions:
  - IDLE: if fifo_rd_en, go to WAIT; otherwise stay in IDLE.
  - WAIT: fifo_data is valid in this cycle.
    - If fifo_data[81]=1, register the built entry into out_entry and go to OUT.
    - If fifo_data[81]=0, out_entry is unchanged, drop_count increments, and the next state is IDLE.
  - OUT: out_valid=1.
    - On out_ready, dispatch_count increments.
    - Next state is WAIT if fifo_rd_en, otherwise IDLE.
    - Without out_ready, stay in OUT.
- Entry build (uses fifo word w):
  - LeafBit = (w[84:82]==0).
  - ExtraWaitBit = !LeafBit.
  - waitcount = LeafBit ? 0 : WaitLatency.
  - out_entry[84:0] = w, unmodified.
- Holding rules:
  - out_entry and out_valid stay stable while out_valid & !out_ready.
  - out_entry holds its last value after acceptance.
- Counters saturate at all-ones and never wrap.
- The FIFO's zero-payload write suppression is transparent to this block. A word that is popped is always processed.

## Timing
- Reset values (asynchronous, while rst=0):
  - state IDLE, out_valid 0, out_entry 0, both counters 0, busy 0.
  - fifo_rd_en evaluates to 0 because state is IDLE and the FIFO is also reset.
- Latency: fifo_rd_en high in cycle N, fifo_data valid in N+1, out_valid high in N+2.
- Throughput:
  - Best case is one entry per 2 cycles: OUT→WAIT→OUT.
  - A dropped word costs 2 cycles: IDLE→WAIT→IDLE.
- fifo_rd_en is never asserted in WAIT. At most one read is outstanding at any time.
- fifo_empty is sampled only in the cycle rd_en is decided. A FIFO that goes empty afterwards does not cancel the read already issued.
- Accept and read in the same cycle (OUT & out_ready & !fifo_empty): the counter increments and the next state is WAIT. out_valid is 0 in the WAIT cycle.
- enable deasserted:
  - No new reads start.
  - An outstanding WAIT still completes.
  - An entry already in OUT still waits for out_ready.
- Reset mid-operation:
  - The block returns to IDLE immediately, with no partial handshake.
  - A word popped but not yet dispatched is lost. The FIFO is reset on the same reset tree, so this is acceptable.

## Test plan
- Reset / idle:
  - Stimulus: rst=0, then release with fifo_empty=1.
  - Required: out_valid=0, fifo_rd_en=0, counters 0, busy=0 for 10 cycles.
- Non-leaf entry:
  - Stimulus: FIFO word children=3'd2, valid=1, payload=32'h0000_0005; out_ready=1.
  - Required: out_valid exactly 2 cycles after rd_en; out_entry[90]=0, [89]=1, [88:85]=4'd9, [84:0]=word; dispatch_count=1.
- Leaf entry:
  - Stimulus: children=0, valid=1, payload=32'hA5.
  - Required: LeafBit=1, ExtraWaitBit=0, waitcount=0.
- Invalid word:
  - Stimulus: word with bit81=0, followed by a valid word.
  - Required: drop_count=1; only the valid word is presented; dispatch_count=1.
- Backpressure:
  - Stimulus: out_ready=0 for 7 cycles with the FIFO non-empty.
  - Required: no fifo_rd_en asserted during OUT; out_entry stable. When out_ready rises, rd_en fires in the same cycle and the next entry appears 2 cycles later.
- Stream and saturation:
  - Stimulus: 8 back-to-back words with out_ready=1.
  - Required: 8 entries at a 2-cycle spacing.
  - Stimulus: force CntWidth=2 and send 5 entries.
  - Required: dispatch_count holds at 3.

Source files
------------

// File: rtl/instr_dispatch_if.sv
// Handshake bundle between the instruction FIFO read port, the dispatcher
// and the reduction table.
interface instr_dispatch_if #(
  parameter int WordWidth  = 85,
  parameter int EntryWidth = 91,
  parameter int CntWidth   = 16
);
  logic                  enable;
  logic                  fifo_empty;
  logic [WordWidth-1:0]  fifo_data;
  logic                  fifo_rd_en;
  logic                  out_valid;
  logic                  out_ready;
  logic [EntryWidth-1:0] out_entry;
  logic [CntWidth-1:0]   dispatch_count;
  logic [CntWidth-1:0]   drop_count;
  logic                  busy;

  modport master (
    output enable, fifo_empty, fifo_data, out_ready,
    input  fifo_rd_en, out_valid, out_entry, dispatch_count, drop_count, busy
  );

  modport slave (
    input  enable, fifo_empty, fifo_data, out_ready,
    output fifo_rd_en, out_valid, out_entry, dispatch_count, drop_count, busy
  );
endinterface

// File: rtl/instr_dispatch.sv
// Pops instruction FIFO words, discards invalid ones and presents the rest as
// reduction-table entries {LeafBit, ExtraWaitBit, waitcount, word}.
module instr_dispatch #(
  parameter int                   FlitWidth   = 82,
  parameter int                   ChildWidth  = 3,
  parameter int                   WaitWidth   = 4,
  parameter logic [WaitWidth-1:0] WaitLatency = 4'd9,
  parameter int                   CntWidth    = 16
) (
  input logic              clk,
  input logic              rst,
  instr_dispatch_if.slave  bus
);
  localparam int WordWidth  = ChildWidth + FlitWidth;
  localparam int EntryWidth = WordWidth + WaitWidth + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t                state_r;
  logic                  out_valid_r;
  logic [EntryWidth-1:0] out_entry_r;
  logic [CntWidth-1:0]   dispatch_count_r;
  logic [CntWidth-1:0]   drop_count_r;
  logic                  busy_r;
  logic                  rd_en_s;

  // Leaf entries (no children) need no extra wait before reduction.
  function automatic logic [EntryWidth-1:0] build_entry(input logic [WordWidth-1:0] w);
    logic leaf;
    leaf = (w[WordWidth-1:FlitWidth] == {ChildWidth{1'b0}});
    return {leaf, ~leaf, (leaf ? {WaitWidth{1'b0}} : WaitLatency), w};
  endfunction

  function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] c);
    logic [CntWidth-1:0] r;
    if (c == {CntWidth{1'b1}}) begin
      r = c;
    end else begin
      r = c + {{(CntWidth-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

  // Read request: never from WAIT, so at most one read is ever outstanding.
  always_comb begin
    rd_en_s = 1'b0;
    case (state_r)
      IDLE:    rd_en_s = bus.enable & ~bus.fifo_empty;
      OUT:     rd_en_s = bus.enable & bus.out_ready & ~bus.fifo_empty;
      default: rd_en_s = 1'b0;
    endcase
  end

  // Dispatch FSM with registered entry, valid, busy and debug counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r          <= IDLE;
      out_valid_r      <= 1'b0;
      out_entry_r      <= {EntryWidth{1'b0}};
      dispatch_count_r <= {CntWidth{1'b0}};
      drop_count_r     <= {CntWidth{1'b0}};
      busy_r           <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (rd_en_s) begin
            state_r <= WAIT;
            busy_r  <= 1'b1;
          end
        end
        WAIT: begin
          if (bus.fifo_data[FlitWidth-1]) begin
            out_entry_r <= build_entry(bus.fifo_data);
            out_valid_r <= 1'b1;
            state_r     <= OUT;
          end else begin
            drop_count_r <= sat_inc(drop_count_r);
            state_r      <= IDLE;
            busy_r       <= 1'b0;
          end
        end
        OUT: begin
          if (bus.out_ready) begin
            dispatch_count_r <= sat_inc(dispatch_count_r);
            out_valid_r      <= 1'b0;
            if (rd_en_s) begin
              state_r <= WAIT;
            end else begin
              state_r <= IDLE;
              busy_r  <= 1'b0;
            end
          end
        end
        default: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.fifo_rd_en     = rd_en_s;
  assign bus.out_valid      = out_valid_r;
  assign bus.out_entry      = out_entry_r;
  assign bus.dispatch_count = dispatch_count_r;
  assign bus.drop_count     = drop_count_r;
  assign bus.busy           = busy_r;
endmodule
